// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
//
// Sequential initiator for the 4-bit combinational ALU. Commands arrive on a
// valid/ready stream. Each accepted command is registered onto the ALU's
// S/A/B/Xin inputs and held for one settle cycle (DRIVE). The ALU's F/Z/V/C
// outputs are then captured, together with the opcode, into a small response
// FIFO. Optional chaining substitutes the last captured F for operand A and
// the last captured C for Xin, so multi-step arithmetic needs no software
// round-trip.
//
// Parameters
//   DEPTH          response FIFO entries (power of two, >= 2)
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_cmd_valid    command present
//   o_cmd_ready    command accepted when i_cmd_valid && o_cmd_ready
//   i_cmd_op       ALU opcode (S encoding)
//   i_cmd_a/b      operands
//   i_cmd_xin      carry/borrow-in
//   i_cmd_chain    1: A := last captured F (i_cmd_a ignored)
//   i_cmd_cin_sel  1: Xin := last captured C (i_cmd_xin ignored)
//   o_alu_s/a/b/xin registered drive to the ALU
//   i_alu_f/z/v/c  ALU results
//   o_rsp_valid    response FIFO non-empty
//   i_rsp_ready    pop when o_rsp_valid && i_rsp_ready
//   o_rsp_op/f/z/v/c head-of-FIFO result, all zero when empty
//   o_busy         command in flight (DRIVE)
// -----------------------------------------------------------------------------
module alu_cmd_driver #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [2:0] i_cmd_op,
  input  logic [3:0] i_cmd_a,
  input  logic [3:0] i_cmd_b,
  input  logic       i_cmd_xin,
  input  logic       i_cmd_chain,
  input  logic       i_cmd_cin_sel,
  output logic [2:0] o_alu_s,
  output logic [3:0] o_alu_a,
  output logic [3:0] o_alu_b,
  output logic       o_alu_xin,
  input  logic [3:0] i_alu_f,
  input  logic       i_alu_z,
  input  logic       i_alu_v,
  input  logic       i_alu_c,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [2:0] o_rsp_op,
  output logic [3:0] o_rsp_f,
  output logic       o_rsp_z,
  output logic       o_rsp_v,
  output logic       o_rsp_c,
  output logic       o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] f;
    logic       z;
    logic       v;
    logic       c;
  } rsp_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic [2:0]  r_alu_s;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic        r_alu_xin;
  logic [3:0]  r_last_f;
  logic        r_last_c;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  rsp_t        r_mem [DEPTH];

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_count_next;
  state_t      w_state_next;
  rsp_t        w_head;
  rsp_t        w_push_data;

  // Ready is registered, so it is only ever high in IDLE; the state term just
  // makes the handshake self-evident.
  assign w_accept    = (r_state == S_IDLE) && i_cmd_valid && r_cmd_ready;
  // Every DRIVE cycle ends in a capture. Space was reserved at accept time,
  // so the push never meets a full FIFO.
  assign w_push      = (r_state == S_DRIVE);
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  assign w_push_data = '{op: r_alu_s, f: i_alu_f, z: i_alu_z, v: i_alu_v, c: i_alu_c};

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW + 1)'(1);
      2'b01:   w_count_next = r_count - (AW + 1)'(1);
      default: w_count_next = r_count;
    endcase

    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_DRIVE;
      S_DRIVE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_alu_s     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_xin   <= 1'b0;
      r_last_f    <= '0;
      r_last_c    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      // Ready for the next cycle: back in IDLE and room for one more result.
      r_cmd_ready <= (w_state_next == S_IDLE) && (w_count_next < DEPTH_C);

      if (w_accept) begin
        r_alu_s   <= i_cmd_op;
        r_alu_a   <= i_cmd_chain   ? r_last_f : i_cmd_a;
        r_alu_b   <= i_cmd_b;
        r_alu_xin <= i_cmd_cin_sel ? r_last_c : i_cmd_xin;
      end

      // Chain state follows captures only; pops never touch it.
      if (w_push) begin
        r_last_f <= i_alu_f;
        r_last_c <= i_alu_c;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      r_count <= w_count_next;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only visible once the count
  // covers it, and the outputs are forced to zero while empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_rsp_valid = (r_count != '0);

  assign o_rsp_op  = o_rsp_valid ? w_head.op : '0;
  assign o_rsp_f   = o_rsp_valid ? w_head.f  : '0;
  assign o_rsp_z   = o_rsp_valid && w_head.z;
  assign o_rsp_v   = o_rsp_valid && w_head.v;
  assign o_rsp_c   = o_rsp_valid && w_head.c;

  assign o_cmd_ready = r_cmd_ready;
  assign o_alu_s     = r_alu_s;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_xin   = r_alu_xin;
  assign o_busy      = (r_state == S_DRIVE);

endmodule
